scan_decoder: RTL
=================

// Module: scan_decoder
// PURPOSE
//  Parametrised registered N-to-2^N one-hot decoder with enable.
//  Two modes: DIRECT, where the output follows input w, and SCAN, where an
//  internal counter steps the active output through all 2^N positions.
//  Drives LED/digit-select style loads in lab top levels.
//  Replaces the fixed 3-to-8 combinational decoder.
// PARAMETERS
//  N    3  select width; output width is 2**N (N >= 1)
//  DIV  4  clock cycles each index is held in SCAN (DIV >= 1)
// PORTS
//  clk    in   1       system clock, rising edge
//  rst    in   1       asynchronous, active-high reset
//  en     in   1       enable; low forces IDLE
//  mode   in   1       0 = DIRECT, 1 = SCAN
//  dir    in   1       SCAN direction: 0 = up, 1 = down
//  w      in   N       DIRECT select / SCAN start index
//  y      out  2**N    registered one-hot output
//  idx    out  N       index currently driven on y
//  valid  out  1       high when y is non-zero
//  wrap   out  1       one-cycle pulse on SCAN wrap-around
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset: state = IDLE; y = 0, idx = 0, valid = 0, wrap = 0; prescaler = 0.
//  - States: IDLE, DIRECT, SCAN. Next state is evaluated at every edge:
//      en = 0           -> IDLE
//      en = 1, mode = 0 -> DIRECT
//      en = 1, mode = 1 -> SCAN
//  - IDLE edge:
//      y = 0, valid = 0, wrap = 0, idx = 0, prescaler = 0.
//  - DIRECT edge:
//      y = 1 << w, idx = w, valid = 1, wrap = 0, prescaler = 0.
//      Latency is 1 cycle from w to y.
//  - SCAN entry edge (previous state != SCAN):
//      idx = w, y = 1 << w, prescaler = 0, wrap = 0, valid = 1.
//  - SCAN edge while already in SCAN:
//      prescaler != DIV-1: prescaler++; y and idx hold; wrap = 0.
//      prescaler == DIV-1: prescaler = 0; idx = idx +/- 1 (mod 2**N,
//        per dir); y = 1 << new idx.
//      wrap = 1 for exactly that edge when the step crosses
//        2**N-1 -> 0 (up) or 0 -> 2**N-1 (down); otherwise 0.
//  - Each index is held exactly DIV cycles.
//  - DIV = 1 steps on every edge; no prescaler register is needed.
//  - dir is sampled on each step edge; changing it mid-scan reverses from
//    the current idx with no skipped index.
//  - w is ignored in SCAN except on the entry edge.
//  - Mode change SCAN -> DIRECT takes effect next edge; scan position is lost.
//    DIRECT -> SCAN restarts from w.
//  - en dropped mid-scan: next edge is IDLE. Re-enable restarts from w.
//  - rst asserted mid-operation clears all outputs immediately (async).
//  - Invariant: y is one-hot or zero at all times; valid == |y.
// TESTING (N = 3, DIV = 4 unless noted)
//  1. rst = 1 with en = 1, mode = 0, w = 5 -> y = 0, valid = 0 while rst is
//     high. Release rst -> y = 8'h20 one edge later.
//  2. DIRECT, w stepped 0..7, one value per cycle -> y = 01, 02, ... 80,
//     each one cycle after w; idx = w; wrap never asserted.
//  3. SCAN up from w = 6 -> y = 40 for 4 cycles, then 80 for 4 cycles,
//     then 01 with wrap = 1 for that single cycle.
//  4. SCAN down from w = 1 -> 02 x4, 01 x4, then 80 with a wrap pulse.
//     Flip dir after 2 more cycles -> at the next step y = 01 (reverse,
//     no skip).
//  5. en dropped mid-scan at idx = 3 -> next edge y = 0, idx = 0.
//     en raised with w = 2 -> y = 04; count restarts at 2.
//  6. DIV = 1, SCAN up from 0 -> y walks 01..80 on consecutive edges;
//     wrap every 8th cycle.

Source files
------------

// File: rtl/scan_decoder_if.sv
// Handshake-free select bus for scan_decoder: control inputs in, decoded outputs back.
interface scan_decoder_if #(
   parameter int N = 3
);
   logic             en;
   logic             mode;
   logic             dir;
   logic [N-1:0]     w;
   logic [2**N-1:0]  y;
   logic [N-1:0]     idx;
   logic             valid;
   logic             wrap;

   modport master (output en, mode, dir, w, input y, idx, valid, wrap);
   modport slave  (input en, mode, dir, w, output y, idx, valid, wrap);
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder. DIRECT follows w with one cycle of
// latency; SCAN walks the active output through every position, holding each
// index DIV cycles and pulsing wrap when the index rolls over either end.
module scan_decoder #(
   parameter int N   = 3,
   parameter int DIV = 4
) (
   input logic          clk,
   input logic          rst,
   scan_decoder_if.slave bus
);
   localparam int W  = 2**N;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    idx_q, idx_nxt;
   logic [W-1:0]    y_q, y_nxt;
   logic            valid_q, valid_nxt;
   logic            wrap_q, wrap_nxt;
   logic            step;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state from en/mode, and the index/valid/wrap that state will drive
   always_comb begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      valid_nxt = 1'b0;
      wrap_nxt  = 1'b0;
      if (bus.en) state_nxt = bus.mode ? SCAN : DIRECT;
      case (state_nxt)
         DIRECT: begin
            idx_nxt   = bus.w;
            valid_nxt = 1'b1;
         end
         SCAN: begin
            valid_nxt = 1'b1;
            if (state != SCAN) begin
               // Entering SCAN always restarts from w
               idx_nxt = bus.w;
            end else if (step) begin
               if (bus.dir) begin
                  idx_nxt  = idx_q - N'(1);
                  wrap_nxt = (idx_q == '0);
               end else begin
                  idx_nxt  = idx_q + N'(1);
                  wrap_nxt = (idx_q == '1);
               end
            end else begin
               idx_nxt = idx_q;
            end
         end
         default: ;
      endcase
   end

   assign y_nxt = valid_nxt ? (W'(1) << idx_nxt) : '0;

   // Prescaler: counts hold cycles inside a running scan; absent when DIV == 1
   generate
      if (DIV > 1) begin : g_presc
         logic [PW-1:0] presc_q;

         // Cleared on any cycle that is not a continuing scan, or on a step
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                                       presc_q <= '0;
            else if (state != SCAN || state_nxt != SCAN || step) presc_q <= '0;
            else                                           presc_q <= presc_q + PW'(1);
         end

         assign step = (presc_q == PW'(DIV - 1));
      end else begin : g_nopresc
         assign step = 1'b1;
      end
   endgenerate

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         idx_q   <= idx_nxt;
         y_q     <= y_nxt;
         valid_q <= valid_nxt;
         wrap_q  <= wrap_nxt;
      end
   end

   assign bus.y     = y_q;
   assign bus.idx   = idx_q;
   assign bus.valid = valid_q;
   assign bus.wrap  = wrap_q;
endmodule
